hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the combinational hazard/forwarding pair: a per-register scoreboard in the ID stage.
//  Tracks every in-flight register write by age and result-availability countdown.
//  Produces the ID stall plus forwarding selects for arbitrary pipeline depth and load latency.
//  Sits between the ID register read and the ID/EXE pipeline register; drives the PC/IF-ID freeze and the EXE operand muxes.
// PARAMETERS
//  REG_W       5  register index width; the register count is 2**REG_W.
//  PIPE_DEPTH  3  number of stages after ID that can hold an un-retired result (EXE, MEM, WB).
//  LOAD_LAT    1  extra cycles before a load result can be forwarded (0..PIPE_DEPTH-1).
//  ZERO_REG    1  1: register 0 is never marked pending and never forwarded.
//  FWD_W       clog2(PIPE_DEPTH+1)  select width (derived localparam, not overridable).
// PORTS
//  clk                    in   1      rising-edge clock.
//  rst                    in   1      asynchronous, active-high reset.
//  issue_valid            in   1      ID holds a real instruction (not a bubble).
//  flush                  in   1      branch taken; the ID instruction is squashed this cycle.
//  source1_ID             in   REG_W  first source register of the ID instruction.
//  source2_ID             in   REG_W  second source register of the ID instruction.
//  is_imm                 in   1      source2 is replaced by an immediate.
//  store_branch_not_equal in   1      store/BNE: source2 is read even when is_imm=1.
//  destination_ID         in   REG_W  destination register of the ID instruction.
//  WriteBack_enable_ID    in   1      the ID instruction writes a register.
//  Memory_R_enable_ID     in   1      the ID instruction is a load.
//  hazard_detected        out  1      stall: freeze PC and IF/ID, inject a bubble into EXE.
//  value1_select          out  FWD_W  0 = register file; k = forward from the stage k cycles past ID.
//  value2_select          out  FWD_W  same encoding, for source2.
// BEHAVIOUR
//  - State per register r: age[r] (0 = not pending; 1..PIPE_DEPTH otherwise) and avail[r] (0..LOAD_LAT).
//  - rst: all age and avail cleared asynchronously. The outputs are combinational from the table, so after reset they read 0.
//  - src2_used = ~is_imm | store_branch_not_equal. src1 is always used.
//  - hz(s) = s used && age[s]!=0 && avail[s]!=0.
//  - hazard_detected = issue_valid & ~flush & (hz(src1) | hz(src2)). Purely combinational; zero-cycle latency.
//  - valueN_select = (sourceN used && age[sourceN]!=0) ? age[sourceN] : 0. The value is still driven while stalled.
//  - Issue fires when issue_valid & ~flush & ~hazard_detected & WriteBack_enable_ID & ~(ZERO_REG && dest==0).
//  - Every clock, for each r with age[r]!=0: age <= (age==PIPE_DEPTH) ? 0 : age+1, and avail <= sat-dec(avail).
//  - On issue: age[dest] <= 1 and avail[dest] <= Memory_R_enable_ID ? LOAD_LAT : 0. This overrides the aging update.
//  - WAW: a new issue to a pending register overwrites its entry, so the youngest producer wins.
//  - Self-dependency (source == destination_ID): the lookup uses pre-update state, so the instruction never stalls on itself.
//  - Stall: nothing issues, and existing entries keep aging, which models the bubble. Maximum stall length is LOAD_LAT cycles.
//  - Flush: the ID instruction neither stalls nor allocates. Entries already in the table are untouched.
//  - Retirement: age wraps PIPE_DEPTH->0. The register file is write-before-read, so select 0 is then correct.
//  - rst mid-stall: the table clears, hazard_detected drops in the same cycle, and no spurious allocation occurs.
// CONFIGURATION
//  HAZARD_STALL_CNT_EN defined:
//    - Extra output stall_cycles (out, 32): registered, reset 0.
//    - Increments on each cycle with hazard_detected=1 and saturates at 32'hFFFF_FFFF.
//  HAZARD_STALL_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  - defines.v carries `REG_LENGTH (default for REG_W), `FORWARDING_LENGTH (default for FWD_W) and the select encodings FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3.
//  - One sub-module, hazard_sb_entry: holds one register's age/avail pair plus its aging and allocate logic.
//  - It is instantiated 2**REG_W times by generate. The top level keeps the lookup muxes, the stall logic and the optional counter.
// TESTING
//  - Reset: assert rst mid-run with entries pending -> hazard_detected=0, both selects=0 immediately; no entries survive.
//  - ALU back-to-back: issue add r3 at cycle t, then sub uses r3 at t+1 -> no stall, value1_select=1.
//    An r3 reader at t+2 sees 2, at t+3 sees 3, at t+4 sees 0.
//  - Load-use: lw r5 at t, add r6,r5,r5 at t+1 -> hazard_detected=1 for 1 cycle.
//    At t+2: issue, value1_select=value2_select=2.
//  - Immediate/store: is_imm=1, source2=r5 pending load, store_branch_not_equal=0 -> no stall. With store_branch_not_equal=1 -> stall.
//  - WAW + zero reg: lw r4 then add r4 back-to-back -> a later reader follows the add's age.
//    Writes to r0 never create an entry (ZERO_REG=1).
//  - Flush + counter: flush=1 with load-use pending -> hazard_detected=0, no allocation.
//    With HAZARD_STALL_CNT_EN, 3 load-use stalls -> stall_cycles=3.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard.
// Forwarding select encoding: 0 reads the register file, k forwards from the
// stage k cycles past ID (EXE=1, MEM=2, WB=3 for the default 3-deep pipe).
package hazard_scoreboard_pkg;

  localparam int REG_LENGTH        = 5;
  localparam int FORWARDING_LENGTH = 2;

  localparam int FWD_RF  = 0;
  localparam int FWD_EXE = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;

  // Bits needed to hold 0..max_val, never less than one bit so a zero load
  // latency still yields a legal vector.
  function automatic int sb_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: the age/availability pair of a single register.
// Age counts cycles since the producer left ID (0 = nothing in flight) and
// wraps to 0 once the producer has passed WB. Avail is the number of cycles
// left before the result can be forwarded.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int AGE_W      = sb_width(PIPE_DEPTH),
  parameter int LAT_W      = sb_width(LOAD_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_alloc,
  input  logic             i_is_load,
  output logic [AGE_W-1:0] o_age,
  output logic [LAT_W-1:0] o_avail
);

  logic [AGE_W-1:0] r_age;
  logic [LAT_W-1:0] r_avail;

  // Allocation restarts the entry and beats the normal aging of an older producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age   <= '0;
      r_avail <= '0;
    end else if (i_alloc) begin
      r_age   <= AGE_W'(1);
      r_avail <= i_is_load ? LAT_W'(LOAD_LAT) : '0;
    end else if (r_age != '0) begin
      r_age   <= (r_age == AGE_W'(PIPE_DEPTH)) ? '0 : r_age + AGE_W'(1);
      r_avail <= (r_avail != '0) ? r_avail - LAT_W'(1) : '0;
    end
  end

  assign o_age   = r_age;
  assign o_avail = r_avail;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register tracking of in-flight writes,
// producing the load-use stall and the EXE operand forwarding selects.
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cycles counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter  int REG_W      = REG_LENGTH,
  parameter  int PIPE_DEPTH = 3,
  parameter  int LOAD_LAT   = 1,
  parameter  int ZERO_REG   = 1,
  localparam int FWD_W      = sb_width(PIPE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             flush,
  input  logic [REG_W-1:0] source1_ID,
  input  logic [REG_W-1:0] source2_ID,
  input  logic             is_imm,
  input  logic             store_branch_not_equal,
  input  logic [REG_W-1:0] destination_ID,
  input  logic             WriteBack_enable_ID,
  input  logic             Memory_R_enable_ID,
  output logic             hazard_detected,
  output logic [FWD_W-1:0] value1_select,
  output logic [FWD_W-1:0] value2_select
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int NREG  = 2 ** REG_W;
  localparam int LAT_W = sb_width(LOAD_LAT);

  logic [FWD_W-1:0] w_age   [NREG];
  logic [LAT_W-1:0] w_avail [NREG];

  logic             w_src2_used;
  logic [FWD_W-1:0] w_age1;
  logic [FWD_W-1:0] w_age2;
  logic             w_pend1;
  logic             w_pend2;
  logic             w_hz1;
  logic             w_hz2;
  logic             w_dest_zero;
  logic             w_issue;

  // The lookups read pre-update state, so an instruction whose source equals
  // its own destination never sees itself as a producer.
  assign w_src2_used = ~is_imm | store_branch_not_equal;
  assign w_age1      = w_age[source1_ID];
  assign w_age2      = w_age[source2_ID];
  assign w_pend1     = (w_age1 != '0);
  assign w_pend2     = w_src2_used & (w_age2 != '0);
  assign w_hz1       = w_pend1 & (w_avail[source1_ID] != '0);
  assign w_hz2       = w_pend2 & (w_avail[source2_ID] != '0);

  assign hazard_detected = issue_valid & ~flush & (w_hz1 | w_hz2);

  // Selects are driven even while stalled; the stalled copy is discarded.
  assign value1_select = w_pend1 ? w_age1 : FWD_W'(FWD_RF);
  assign value2_select = w_pend2 ? w_age2 : FWD_W'(FWD_RF);

  assign w_dest_zero = (ZERO_REG != 0) && (destination_ID == '0);
  assign w_issue     = issue_valid & ~flush & ~hazard_detected &
                       WriteBack_enable_ID & ~w_dest_zero;

  // One slot per architectural register; only the destination slot allocates.
  for (genvar g = 0; g < NREG; g++) begin : g_entry
    hazard_sb_entry #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .AGE_W      (FWD_W),
      .LAT_W      (LAT_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .i_alloc   (w_issue && (destination_ID == REG_W'(g))),
      .i_is_load (Memory_R_enable_ID),
      .o_age     (w_age[g]),
      .o_avail   (w_avail[g])
    );
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (hazard_detected && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (default parameters).
// The reference model remembers, per register, the cycle of its youngest
// producer and whether it was a load; age and load-pending state follow from
// the elapsed cycle count.
module tb_hazard_scoreboard;

  localparam int PD = 3;
  localparam int LL = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] source1_ID = '0;
  logic [4:0] source2_ID = '0;
  logic       is_imm = 1'b0;
  logic       store_branch_not_equal = 1'b0;
  logic [4:0] destination_ID = '0;
  logic       WriteBack_enable_ID = 1'b0;
  logic       Memory_R_enable_ID = 1'b0;
  logic       hazard_detected;
  logic [1:0] value1_select;
  logic [1:0] value2_select;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard dut (
    .clk                    (clk),
    .rst                    (rst),
    .issue_valid            (issue_valid),
    .flush                  (flush),
    .source1_ID             (source1_ID),
    .source2_ID             (source2_ID),
    .is_imm                 (is_imm),
    .store_branch_not_equal (store_branch_not_equal),
    .destination_ID         (destination_ID),
    .WriteBack_enable_ID    (WriteBack_enable_ID),
    .Memory_R_enable_ID     (Memory_R_enable_ID),
    .hazard_detected        (hazard_detected),
    .value1_select          (value1_select),
    .value2_select          (value2_select)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles           (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int iss [32];
  bit ld_r [32];
  int cyc = 0;
  int stall_cnt = 0;

  logic       o_hz;
  logic [1:0] o_s1;
  logic [1:0] o_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_age(input int r);
    int d;
    if (r == 0) return 0;
    d = cyc - iss[r];
    if (d >= 1 && d <= PD) return d;
    return 0;
  endfunction

  // A load result is forwardable once it has been in flight for more than LL cycles.
  function automatic bit m_busy(input int r);
    int a;
    a = m_age(r);
    return (a != 0) && ld_r[r] && (a <= LL);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      iss[i]  = -1000;
      ld_r[i] = 1'b0;
    end
    stall_cnt = 0;
  endtask

  // Present one ID instruction for one cycle, check against the model, then clock it.
  task automatic step(input logic v, input logic fl, input int s1, input int s2,
                      input logic imm, input logic sb, input int d,
                      input logic wb, input logic ld, input string tag);
    bit e_hz;
    bit used2;
    int e_s1;
    int e_s2;
    @(negedge clk);
    issue_valid            = v;
    flush                  = fl;
    source1_ID             = s1[4:0];
    source2_ID             = s2[4:0];
    is_imm                 = imm;
    store_branch_not_equal = sb;
    destination_ID         = d[4:0];
    WriteBack_enable_ID    = wb;
    Memory_R_enable_ID     = ld;
    #1;
    used2 = !imm || sb;
    e_s1  = m_age(s1);
    e_s2  = used2 ? m_age(s2) : 0;
    e_hz  = v && !fl && (m_busy(s1) || (used2 && m_busy(s2)));
    chk({tag, "_hz"}, 32'(hazard_detected), 32'(e_hz));
    chk({tag, "_sel1"}, 32'(value1_select), e_s1);
    chk({tag, "_sel2"}, 32'(value2_select), e_s2);
    o_hz = hazard_detected;
    o_s1 = value1_select;
    o_s2 = value2_select;
    @(posedge clk);
    if (e_hz) stall_cnt++;
    if (v && !fl && !e_hz && wb && d != 0) begin
      iss[d]  = cyc;
      ld_r[d] = ld;
    end
    cyc++;
  endtask

  // Asynchronous reset raised between clock edges; outputs must drop at once.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_hz"}, 32'(hazard_detected), 0);
    chk({tag, "_sel1"}, 32'(value1_select), 0);
    chk({tag, "_sel2"}, 32'(value2_select), 0);
    model_clear();
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, "_cnt"}, stall_cycles, 0);
`endif
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #3;
    chk("rst_init_hz", 32'(hazard_detected), 0);
    chk("rst_init_sel1", 32'(value1_select), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // ALU back-to-back: add r3, then readers at increasing distance
    step(1, 0, 1, 2, 0, 0, 3, 1, 0, "alu_add");
    step(1, 0, 3, 0, 0, 0, 7, 0, 0, "alu_t1");
    chk("alu_t1_nostall", 32'(o_hz), 0);
    chk("alu_t1_sel", 32'(o_s1), 1);
    step(1, 0, 3, 0, 0, 0, 7, 0, 0, "alu_t2");
    chk("alu_t2_sel", 32'(o_s1), 2);
    step(1, 0, 3, 0, 0, 0, 7, 0, 0, "alu_t3");
    chk("alu_t3_sel", 32'(o_s1), 3);
    step(1, 0, 3, 0, 0, 0, 7, 0, 0, "alu_t4");
    chk("alu_t4_sel", 32'(o_s1), 0);

    // Load-use: one stall, then forward from two stages past ID
    step(1, 0, 0, 0, 1, 0, 5, 1, 1, "lu_lw");
    step(1, 0, 5, 5, 0, 0, 6, 1, 0, "lu_use");
    chk("lu_stall", 32'(o_hz), 1);
    step(1, 0, 5, 5, 0, 0, 6, 1, 0, "lu_retry");
    chk("lu_retry_hz", 32'(o_hz), 0);
    chk("lu_retry_sel1", 32'(o_s1), 2);
    chk("lu_retry_sel2", 32'(o_s2), 2);

    // Immediate operand hides source2 unless it is a store/BNE
    step(1, 0, 0, 0, 1, 0, 5, 1, 1, "imm_lw");
    step(1, 0, 0, 5, 1, 0, 0, 0, 0, "imm_use");
    chk("imm_nostall", 32'(o_hz), 0);
    step(1, 0, 0, 0, 1, 0, 5, 1, 1, "st_lw");
    step(1, 0, 0, 5, 1, 1, 0, 0, 0, "st_use");
    chk("st_stall", 32'(o_hz), 1);
    step(1, 0, 0, 5, 1, 1, 0, 0, 0, "st_retry");

    // WAW: youngest producer wins; r0 writes never allocate
    step(1, 0, 0, 0, 1, 0, 4, 1, 1, "waw_lw");
    step(1, 0, 0, 0, 1, 0, 4, 1, 0, "waw_add");
    step(1, 0, 4, 0, 1, 0, 0, 0, 0, "waw_rd");
    chk("waw_sel", 32'(o_s1), 1);
    step(1, 0, 0, 0, 1, 0, 0, 1, 1, "zero_wr");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "zero_rd");
    chk("zero_sel1", 32'(o_s1), 0);
    chk("zero_hz", 32'(o_hz), 0);

    // Flush with a load-use pending: no stall and no allocation
    step(1, 0, 0, 0, 1, 0, 7, 1, 1, "fl_lw");
    step(1, 1, 7, 0, 1, 0, 8, 1, 0, "fl_use");
    chk("fl_nostall", 32'(o_hz), 0);
    step(1, 0, 8, 0, 1, 0, 0, 0, 0, "fl_rd");
    chk("fl_noalloc", 32'(o_s1), 0);

    // Reset in the middle of a stall
    step(1, 0, 0, 0, 1, 0, 5, 1, 1, "mrst_lw");
    @(negedge clk);
    source1_ID = 5'd5; source2_ID = 5'd5; is_imm = 1'b0;
    destination_ID = 5'd6; WriteBack_enable_ID = 1'b1; Memory_R_enable_ID = 1'b0;
    #1;
    chk("mrst_pre_hz", 32'(hazard_detected), 1);
    do_reset("mrst");
    step(1, 0, 5, 6, 0, 0, 0, 0, 0, "mrst_after");
    chk("mrst_r5_gone", 32'(o_s1), 0);
    chk("mrst_r6_noalloc", 32'(o_s2), 0);

    // Three load-use stalls after reset
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1, 0, 9, 1, 1, "cnt_lw");
      step(1, 0, 9, 0, 1, 0, 10, 1, 0, "cnt_use");
      chk("cnt_stall", 32'(o_hz), 1);
      step(1, 0, 9, 0, 1, 0, 10, 1, 0, "cnt_retry");
    end
`ifdef HAZARD_STALL_CNT_EN
    #1 chk("cnt_three", stall_cycles, 3);
`endif

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        do_reset("rnd_rst");
      end else begin
        step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
             int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 4, "rnd");
      end
`ifdef HAZARD_STALL_CNT_EN
      if (n % 100 == 99) chk("rnd_cnt", stall_cycles, stall_cnt);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
